// File: rtl/dac_spi_sched.sv
// rtl/dac_spi_sched.sv - coalescing round-robin DAC write scheduler for a shared SPI master
// Each channel has one shadow value and a pending bit. Pending channels are issued one frame at a time.
module dac_spi_sched #(
   parameter int NUM_CH = 4,
   parameter int VAL_W = 12,
   parameter int CMD_W = 2,
   parameter logic [CMD_W-1:0] CMD_WRITE = 2'b11,
   parameter int ADDR_W = $clog2(NUM_CH),
   parameter int FRAME_W = CMD_W + ADDR_W + VAL_W
) (
   input  logic                    clk_i,
   input  logic                    arst_i,
   input  logic [NUM_CH-1:0]       wr_i,
   input  logic [NUM_CH*VAL_W-1:0] val_i,
   output logic [NUM_CH-1:0]       pend_o,
   output logic [NUM_CH-1:0]       done_o,
   output logic                    busy_o,
   output logic [FRAME_W-1:0]      spi_data_o,
   output logic                    spi_wre_o,
   input  logic                    spi_rdy_i
);

   typedef enum logic [1:0] {IDLE, WAIT_ACC, WAIT_DONE} state_t;

   state_t             state;
   logic [VAL_W-1:0]   sh [NUM_CH];
   logic [NUM_CH-1:0]  pend;
   logic [ADDR_W-1:0]  rr_ptr;
   logic [ADDR_W-1:0]  cur;
   logic [ADDR_W-1:0]  gnt;
   logic [ADDR_W-1:0]  idx;
   logic               gnt_ok;
   logic               fire;
   logic [NUM_CH-1:0]  clr;

   // Scan downward so the pending channel closest to rr_ptr is the last one kept.
   always_comb begin
      gnt_ok = 1'b0;
      gnt = '0;
      idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = rr_ptr + ADDR_W'(i);
         if (pend[idx]) begin
            gnt_ok = 1'b1;
            gnt = idx;
         end
      end
   end

   assign fire = (state == IDLE) && gnt_ok && spi_rdy_i;
   assign clr = fire ? (NUM_CH'(1) << gnt) : '0;
   assign pend_o = pend;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state <= IDLE;
         pend <= '0;
         rr_ptr <= '0;
         cur <= '0;
         done_o <= '0;
         busy_o <= 1'b0;
         spi_data_o <= '0;
         spi_wre_o <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) sh[k] <= '0;
      end else begin
         done_o <= '0;
         // A write on the grant edge re-arms the channel; the frame keeps the old shadow value.
         pend <= (pend & ~clr) | wr_i;
         for (int k = 0; k < NUM_CH; k++) begin
            if (wr_i[k]) sh[k] <= val_i[k*VAL_W +: VAL_W];
         end
         case (state)
            IDLE: begin
               if (fire) begin
                  spi_data_o <= {CMD_WRITE, gnt, sh[gnt]};
                  spi_wre_o <= 1'b1;
                  cur <= gnt;
                  rr_ptr <= gnt + ADDR_W'(1);
                  busy_o <= 1'b1;
                  state <= WAIT_ACC;
               end
            end
            WAIT_ACC: begin
               spi_wre_o <= 1'b0;
               if (!spi_rdy_i) state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (spi_rdy_i) begin
                  done_o[cur] <= 1'b1;
                  busy_o <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
